// File: rtl/dcm_rst_seq_pkg.sv
// Shared definitions for the DCM reset/lock sequencer.
//   - seq_state_t : sequencer state encodings (also exported on seq_state)
//   - RETRY_W     : width of the saturating retry counter
//   - RETRY_MAX   : saturation value of the retry counter
//   - max4()      : helper for sizing the shared cycle counter
package dcm_rst_seq_pkg;

   localparam int RETRY_W = 4;
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   typedef enum logic [2:0] {
      ST_HOLD1  = 3'd0,
      ST_WAIT1  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_WAIT2  = 3'd3,
      ST_POST   = 3'd4,
      ST_RUN    = 3'd5
   } seq_state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous reset.
// Ports:
//   clk - destination clock
//   rst - asynchronous, active-high reset; loads every flop with RST_VAL
//   d   - asynchronous input bit
//   q   - synchronized output (last flop of the chain)
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the input through the chain; only the last flop is used downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/dcm_rst_seq.sv
// Reset/lock sequencer for a cascaded pair of DCMs running on the free-running
// reference clock. Holds the first DCM in reset, waits for it to lock and
// settle, then releases the second DCM, waits for both to be locked for a
// while, and finally releases the active-low system reset. Any loss of a
// qualified lock restarts the sequence; lock timeouts retry.
// Ports:
//   clk          - free-running reference clock
//   rst          - asynchronous, active-high reset
//   stage1_ready - first DCM locked (asynchronous to clk)
//   stage2_ready - second DCM locked (asynchronous to clk)
//   stage1_rst   - active-high reset to the first DCM
//   stage2_rst   - active-high reset to the second DCM
//   sys_rst_b    - active-low reset to the rest of the design
//   lock_lost    - sticky flag, set when a qualified lock drops
//   retry_cnt    - saturating count of lock timeouts
//   seq_state    - current state encoding for debug
module dcm_rst_seq
   import dcm_rst_seq_pkg::*;
#(
   parameter int RST_HOLD    = 4,
   parameter int SETTLE      = 15,
   parameter int POST_LOCK   = 8,
   parameter int TIMEOUT     = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stage1_ready,
   input  logic               stage2_ready,
   output logic               stage1_rst,
   output logic               stage2_rst,
   output logic               sys_rst_b,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         seq_state
);

   localparam int CNT_W = $clog2(max4(RST_HOLD, SETTLE, POST_LOCK, TIMEOUT)) + 1;

   localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] SETTLE_TC  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] POST_TC    = CNT_W'(POST_LOCK - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT - 1);

   logic             s1;
   logic             s2;
   logic             rel_hold;
   seq_state_t       state;
   seq_state_t       nxt;
   logic [CNT_W-1:0] counter;
   logic             loss_evt;
   logic             tmo_evt;

   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_s1 (
      .clk (clk),
      .rst (rst),
      .d   (stage1_ready),
      .q   (s1)
   );

   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_s2 (
      .clk (clk),
      .rst (rst),
      .d   (stage2_ready),
      .q   (s2)
   );

   // Reset release: stays high for SYNC_STAGES edges after rst falls so the
   // FSM never moves on the edge that races the reset deassertion.
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rel (
      .clk (clk),
      .rst (rst),
      .d   (1'b0),
      .q   (rel_hold)
   );

   // Next-state decode. Inside each state, lock loss is checked first, then
   // completion, then timeout, so a drop coinciding with terminal count is
   // treated as lock loss and never bumps the retry counter. s2 is only
   // looked at once stage2 has actually been released from reset.
   always_comb begin
      nxt      = state;
      loss_evt = 1'b0;
      tmo_evt  = 1'b0;
      if (rel_hold) begin
         nxt = ST_HOLD1;
      end else begin
         case (state)
            ST_HOLD1: begin
               if (counter == HOLD_TC) nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
               if (s1) begin
                  nxt = ST_SETTLE;
               end else if (counter == TIMEOUT_TC) begin
                  nxt     = ST_HOLD1;
                  tmo_evt = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (!s1) begin
                  nxt      = ST_HOLD1;
                  loss_evt = 1'b1;
               end else if (counter == SETTLE_TC) begin
                  nxt = ST_WAIT2;
               end
            end
            ST_WAIT2: begin
               if (!s1) begin
                  nxt      = ST_HOLD1;
                  loss_evt = 1'b1;
               end else if (s2) begin
                  nxt = ST_POST;
               end else if (counter == TIMEOUT_TC) begin
                  nxt     = ST_HOLD1;
                  tmo_evt = 1'b1;
               end
            end
            ST_POST: begin
               if (!s1 || !s2) begin
                  nxt      = ST_HOLD1;
                  loss_evt = 1'b1;
               end else if (counter == POST_TC) begin
                  nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!s1 || !s2) begin
                  nxt      = ST_HOLD1;
                  loss_evt = 1'b1;
               end
            end
            default: nxt = ST_HOLD1;
         endcase
      end
   end

   // State, counter and registered outputs. Outputs are decoded from the
   // next state so they switch on the same edge as the state itself; the
   // counter restarts on every state change and saturates rather than wraps
   // while idling in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_HOLD1;
         counter    <= '0;
         stage1_rst <= 1'b1;
         stage2_rst <= 1'b1;
         sys_rst_b  <= 1'b0;
         lock_lost  <= 1'b0;
         retry_cnt  <= '0;
      end else begin
         state <= nxt;
         if (rel_hold || (nxt != state)) begin
            counter <= '0;
         end else if (counter != {CNT_W{1'b1}}) begin
            counter <= counter + CNT_W'(1);
         end
         stage1_rst <= (nxt == ST_HOLD1);
         stage2_rst <= (nxt == ST_HOLD1) || (nxt == ST_WAIT1) || (nxt == ST_SETTLE);
         sys_rst_b  <= (nxt == ST_RUN);
         if (loss_evt) lock_lost <= 1'b1;
         if (tmo_evt && (retry_cnt != RETRY_MAX)) retry_cnt <= retry_cnt + RETRY_W'(1);
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_dcm_rst_seq.sv
// Directed self-checking bench for dcm_rst_seq with default parameters.
// Edge counts below are measured from the negedge on which a stimulus is
// applied to the negedge at which the awaited state is first observed.
module tb_dcm_rst_seq;
   import dcm_rst_seq_pkg::*;

   logic               clk;
   logic               rst;
   logic               stage1_ready;
   logic               stage2_ready;
   logic               stage1_rst;
   logic               stage2_rst;
   logic               sys_rst_b;
   logic               lock_lost;
   logic [RETRY_W-1:0] retry_cnt;
   logic [2:0]         seq_state;

   int checks   = 0;
   int failures = 0;
   int s2LowCnt = 0;

   dcm_rst_seq dut (
      .clk          (clk),
      .rst          (rst),
      .stage1_ready (stage1_ready),
      .stage2_ready (stage2_ready),
      .stage1_rst   (stage1_rst),
      .stage2_rst   (stage2_rst),
      .sys_rst_b    (sys_rst_b),
      .lock_lost    (lock_lost),
      .retry_cnt    (retry_cnt),
      .seq_state    (seq_state)
   );

   // Free-running reference clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts negedges on which stage2 was out of reset.
   always @(negedge clk) begin
      if (stage2_rst === 1'b0) s2LowCnt <= s2LowCnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic rdy1, input logic rdy2);
      rst          = r;
      stage1_ready = rdy1;
      stage2_ready = rdy2;
   endtask

   // Wait (bounded) until seq_state equals target, sampling on negedges.
   task automatic waitState(input logic [2:0] target, input int budget, output int edges);
      edges = 0;
      while (seq_state !== target && edges < budget) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
   endtask

   // Full reset: rst high for three cycles, released on a negedge.
   task automatic doReset(input logic rdy1, input logic rdy2);
      applyStimulus(1'b1, rdy1, rdy2);
      repeat (3) @(negedge clk);
      applyStimulus(1'b0, rdy1, rdy2);
   endtask

   initial begin
      int e;
      int s2Before;

      applyStimulus(1'b1, 1'b0, 1'b0);

      // ---------------- Nominal start ----------------
      repeat (3) @(negedge clk);
      checkOutput("rst_state", seq_state, ST_HOLD1);
      checkOutput("rst_s1rst", stage1_rst, 1);
      checkOutput("rst_s2rst", stage2_rst, 1);
      checkOutput("rst_sysrstb", sys_rst_b, 0);
      checkOutput("rst_locklost", lock_lost, 0);
      checkOutput("rst_retry", retry_cnt, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitState(ST_WAIT1, 50, e);
      checkOutput("nom_to_wait1", e, 6);
      checkOutput("nom_wait1_s1rst", stage1_rst, 0);
      checkOutput("nom_wait1_s2rst", stage2_rst, 1);
      repeat (20) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitState(ST_SETTLE, 20, e);
      checkOutput("nom_to_settle", e, 3);
      checkOutput("nom_settle_s2rst", stage2_rst, 1);
      waitState(ST_WAIT2, 40, e);
      checkOutput("nom_to_wait2", e, 15);
      checkOutput("nom_wait2_s2rst", stage2_rst, 0);
      checkOutput("nom_wait2_sysrstb", sys_rst_b, 0);
      repeat (30) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitState(ST_POST, 20, e);
      checkOutput("nom_to_post", e, 3);
      checkOutput("nom_post_sysrstb", sys_rst_b, 0);
      waitState(ST_RUN, 20, e);
      checkOutput("nom_to_run", e, 8);
      checkOutput("nom_run_sysrstb", sys_rst_b, 1);
      checkOutput("nom_run_locklost", lock_lost, 0);
      checkOutput("nom_run_retry", retry_cnt, 0);

      // ---------------- Lock loss in RUN ----------------
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      checkOutput("loss_pre_sysrstb", sys_rst_b, 1);
      checkOutput("loss_pre_s2rst", stage2_rst, 0);
      waitState(ST_HOLD1, 10, e);
      checkOutput("loss_to_hold1", e, 1);
      checkOutput("loss_sysrstb", sys_rst_b, 0);
      checkOutput("loss_s2rst", stage2_rst, 1);
      checkOutput("loss_s1rst", stage1_rst, 1);
      checkOutput("loss_locklost", lock_lost, 1);
      repeat (2) @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitState(ST_RUN, 200, e);
      checkOutput("loss_rerun_edges", e, 27);
      checkOutput("loss_rerun_sysrstb", sys_rst_b, 1);
      checkOutput("loss_rerun_locklost", lock_lost, 1);
      checkOutput("loss_rerun_retry", retry_cnt, 0);

      // ---------------- Stale stage2 ready ----------------
      doReset(1'b0, 1'b1);
      waitState(ST_WAIT1, 50, e);
      checkOutput("stale_to_wait1", e, 6);
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitState(ST_SETTLE, 20, e);
      checkOutput("stale_to_settle", e, 3);
      waitState(ST_WAIT2, 40, e);
      checkOutput("stale_settle_len", e, 15);
      checkOutput("stale_wait2_s2rst", stage2_rst, 0);
      waitState(ST_POST, 20, e);
      checkOutput("stale_to_post", e, 1);
      waitState(ST_RUN, 20, e);
      checkOutput("stale_to_run", e, 8);
      checkOutput("stale_run_sysrstb", sys_rst_b, 1);

      // ---------------- Drop during SETTLE ----------------
      doReset(1'b0, 1'b1);
      waitState(ST_WAIT1, 50, e);
      s2Before = s2LowCnt;
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitState(ST_SETTLE, 20, e);
      checkOutput("drop_to_settle", e, 3);
      repeat (7) @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitState(ST_HOLD1, 10, e);
      checkOutput("drop_to_hold1", e, 3);
      checkOutput("drop_locklost", lock_lost, 1);
      checkOutput("drop_retry", retry_cnt, 0);
      checkOutput("drop_s2rst_low_cycles", s2LowCnt - s2Before, 0);

      // ---------------- Async reset mid-POST ----------------
      applyStimulus(1'b0, 1'b1, 1'b1);
      waitState(ST_POST, 100, e);
      checkOutput("async_in_post", seq_state, ST_POST);
      checkOutput("async_pre_locklost", lock_lost, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_state", seq_state, ST_HOLD1);
      checkOutput("async_s1rst", stage1_rst, 1);
      checkOutput("async_s2rst", stage2_rst, 1);
      checkOutput("async_sysrstb", sys_rst_b, 0);
      checkOutput("async_locklost", lock_lost, 0);
      checkOutput("async_retry", retry_cnt, 0);
      rst = 1'b0;
      waitState(ST_WAIT1, 50, e);
      checkOutput("async_restart_wait1", e, 6);
      waitState(ST_RUN, 100, e);
      checkOutput("async_restart_run", e, 25);

      // ---------------- Stage1 timeout ----------------
      doReset(1'b0, 1'b0);
      waitState(ST_WAIT1, 50, e);
      checkOutput("tmo_to_wait1", e, 6);
      waitState(ST_HOLD1, 1100, e);
      checkOutput("tmo_wait1_len", e, 1000);
      checkOutput("tmo_retry1", retry_cnt, 1);
      checkOutput("tmo_s1rst", stage1_rst, 1);
      checkOutput("tmo_locklost", lock_lost, 0);
      waitState(ST_WAIT1, 10, e);
      checkOutput("tmo_hold_len", e, 4);
      for (int k = 2; k <= 15; k++) begin
         waitState(ST_HOLD1, 1100, e);
         waitState(ST_WAIT1, 10, e);
      end
      checkOutput("tmo_retry15", retry_cnt, 15);
      waitState(ST_HOLD1, 1100, e);
      checkOutput("tmo_16th_len", e, 1000);
      checkOutput("tmo_retry_sat16", retry_cnt, 15);
      waitState(ST_WAIT1, 10, e);
      waitState(ST_HOLD1, 1100, e);
      checkOutput("tmo_retry_sat17", retry_cnt, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
